// File: rtl/cacheline_adaptor_pkg.sv
// Shared constants and FSM state encoding for the cache-line <-> memory-burst adaptor.
// Also holds the line-alignment helper used to build the burst-side address.
package cache_types;

  localparam int unsigned s_line     = 256;
  localparam int unsigned s_burst    = 64;
  localparam int unsigned num_bursts = s_line / s_burst;
  localparam int unsigned addr_w     = 32;
  localparam int unsigned offset_w   = $clog2(s_line / 8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Clear the byte-offset bits so the address points at the start of a line.
  function automatic logic [addr_w-1:0] line_align(input logic [addr_w-1:0] addr);
    logic [addr_w-1:0] mask;
    mask = {addr_w{1'b1}} << offset_w;
    return addr & mask;
  endfunction

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Cache-side and memory-side signals of the adaptor, bundled in one interface.
// master = environment (cache + memory), slave = the adaptor itself.
interface cacheline_adaptor_if;
  import cache_types::*;

  logic [s_line-1:0]  line_i;
  logic [s_line-1:0]  line_o;
  logic [addr_w-1:0]  address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [s_burst-1:0] burst_i;
  logic [s_burst-1:0] burst_o;
  logic [addr_w-1:0]  address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

endinterface

// File: rtl/cacheline_adaptor.sv
// Converts one cache-line read/write request into num_bursts memory bursts,
// assembling read bursts into a line and slicing a written line into bursts.
module cacheline_adaptor #(
  parameter int unsigned s_line     = 256,
  parameter int unsigned s_burst    = 64,
  parameter int unsigned num_bursts = 4
) (
  input  logic                clk,
  input  logic                rst,
  cacheline_adaptor_if.slave  bus
);
  import cache_types::state_t;
  import cache_types::IDLE;
  import cache_types::READ;
  import cache_types::WRITE;
  import cache_types::DONE;
  import cache_types::addr_w;
  import cache_types::line_align;

  localparam int unsigned          cnt_w    = (num_bursts > 1) ? $clog2(num_bursts) : 1;
  localparam logic [cnt_w-1:0]     cnt_last = cnt_w'(num_bursts - 1);
  localparam logic [cnt_w-1:0]     cnt_one  = cnt_w'(1);

  state_t              state_q, state_d;
  logic [cnt_w-1:0]    cnt_q,   cnt_d;
  logic [addr_w-1:0]   addr_q,  addr_d;
  logic [s_line-1:0]   wline_q, wline_d;
  logic [s_line-1:0]   rline_q, rline_d;
  logic [s_burst-1:0]  burst_q, burst_d;
  logic                read_q,  read_d;
  logic                write_q, write_d;
  logic                resp_q,  resp_d;

  // Next-state, burst counter and data-path updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;

    case (state_q)
      IDLE: begin
        if (bus.write_i) begin
          wline_d = bus.line_i;
          addr_d  = line_align(bus.address_i);
          cnt_d   = {cnt_w{1'b0}};
          state_d = WRITE;
        end else if (bus.read_i) begin
          addr_d  = line_align(bus.address_i);
          cnt_d   = {cnt_w{1'b0}};
          state_d = READ;
        end else begin
          state_d = IDLE;
        end
      end

      READ: begin
        if (bus.resp_i) begin
          rline_d[int'(cnt_q) * s_burst +: s_burst] = bus.burst_i;
          cnt_d = cnt_q + cnt_one;
          if (cnt_q == cnt_last) begin
            state_d = DONE;
          end else begin
            state_d = READ;
          end
        end else begin
          state_d = READ;
        end
      end

      WRITE: begin
        if (bus.resp_i) begin
          cnt_d = cnt_q + cnt_one;
          if (cnt_q == cnt_last) begin
            state_d = DONE;
          end else begin
            state_d = WRITE;
          end
        end else begin
          state_d = WRITE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered copies of what the next state implies.
  always_comb begin
    read_d  = (state_d == READ);
    write_d = (state_d == WRITE);
    resp_d  = (state_d == DONE);
    burst_d = wline_d[int'(cnt_d) * s_burst +: s_burst];
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {cnt_w{1'b0}};
      addr_q  <= {addr_w{1'b0}};
      wline_q <= {s_line{1'b0}};
      rline_q <= {s_line{1'b0}};
      burst_q <= {s_burst{1'b0}};
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
      burst_q <= burst_d;
      read_q  <= read_d;
      write_q <= write_d;
      resp_q  <= resp_d;
    end
  end

  assign bus.line_o    = rline_q;
  assign bus.burst_o   = burst_q;
  assign bus.address_o = addr_q;
  assign bus.read_o    = read_q;
  assign bus.write_o   = write_q;
  assign bus.resp_o    = resp_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: a per-cycle vector table for reset, read,
// write and priority, then hand-written gapped-read and reset-abort sequences.
module tb_cacheline_adaptor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_adaptor_if bus_if();

  cacheline_adaptor #(
    .s_line(256),
    .s_burst(64),
    .num_bursts(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  typedef struct {
    logic        rst;
    logic        rd;
    logic        wr;
    logic        rsp;
    logic [31:0] addr;
    logic [63:0] burst;
    logic        e_rd;
    logic        e_wr;
    logic        e_resp;
    logic [31:0] e_addr;
    logic        chk_burst;
    logic [63:0] e_burst;
  } vec_t;

  localparam logic [63:0] B0 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B1 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B2 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B3 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] WA = 64'hA1A1_A1A1_0000_000A;
  localparam logic [63:0] WB = 64'hB2B2_B2B2_0000_000B;
  localparam logic [63:0] WC = 64'hC3C3_C3C3_0000_000C;
  localparam logic [63:0] WD = 64'hD4D4_D4D4_0000_000D;
  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

  int checks = 0;
  int errors = 0;
  vec_t vecs[15];
  logic [63:0] cdat[4];
  logic [63:0] fdat[4];
  logic        gap_pat[7];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic rd, input logic wr, input logic rsp,
                       input logic [31:0] addr, input logic [63:0] burst);
    rst              = r;
    bus_if.read_i    = rd;
    bus_if.write_i   = wr;
    bus_if.resp_i    = rsp;
    bus_if.address_i = addr;
    bus_if.burst_i   = burst;
  endtask

  initial begin
    // rst, rd, wr, rsp, addr, burst | e_rd, e_wr, e_resp, e_addr, chk_burst, e_burst
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         64'h0,  1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 64'h0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         64'h0,  1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 64'h0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         JUNK,   1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 64'h0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 64'h0,  1'b1, 1'b0, 1'b0, 32'h0000_1220, 1'b0, 64'h0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_1234, B0,     1'b1, 1'b0, 1'b0, 32'h0000_1220, 1'b0, 64'h0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_1234, B1,     1'b1, 1'b0, 1'b0, 32'h0000_1220, 1'b0, 64'h0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_1234, B2,     1'b1, 1'b0, 1'b0, 32'h0000_1220, 1'b0, 64'h0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_1234, B3,     1'b0, 1'b0, 1'b1, 32'h0000_1220, 1'b0, 64'h0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 64'h0,  1'b0, 1'b0, 1'b0, 32'h0000_1220, 1'b0, 64'h0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_ABCD, 64'h0,  1'b0, 1'b1, 1'b0, 32'h0000_ABC0, 1'b1, WA};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_ABCD, JUNK,   1'b0, 1'b1, 1'b0, 32'h0000_ABC0, 1'b1, WB};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_ABCD, JUNK,   1'b0, 1'b1, 1'b0, 32'h0000_ABC0, 1'b1, WC};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_ABCD, JUNK,   1'b0, 1'b1, 1'b0, 32'h0000_ABC0, 1'b1, WD};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_ABCD, JUNK,   1'b0, 1'b0, 1'b1, 32'h0000_ABC0, 1'b0, 64'h0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         64'h0,  1'b0, 1'b0, 1'b0, 32'h0000_ABC0, 1'b0, 64'h0};

    cdat[0] = 64'hC0C0_0000_0000_0001;
    cdat[1] = 64'hC1C1_0000_0000_0002;
    cdat[2] = 64'hC2C2_0000_0000_0003;
    cdat[3] = 64'hC3C3_0000_0000_0004;
    fdat[0] = 64'hF0F0_1234_5678_0000;
    fdat[1] = 64'hF1F1_1234_5678_1111;
    fdat[2] = 64'hF2F2_1234_5678_2222;
    fdat[3] = 64'hF3F3_1234_5678_3333;
    gap_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    bus_if.line_i = {WD, WC, WB, WA};
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);

    // Table: reset, stray resp_i, read with 4 back-to-back bursts (resp_o on the
    // 5th edge after acceptance, i.e. the 6th cycle), then read+write together.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].rst, vecs[i].rd, vecs[i].wr, vecs[i].rsp, vecs[i].addr, vecs[i].burst);
      step();
      chk($sformatf("v%0d read_o", i),    {255'h0, bus_if.read_o},  {255'h0, vecs[i].e_rd});
      chk($sformatf("v%0d write_o", i),   {255'h0, bus_if.write_o}, {255'h0, vecs[i].e_wr});
      chk($sformatf("v%0d resp_o", i),    {255'h0, bus_if.resp_o},  {255'h0, vecs[i].e_resp});
      chk($sformatf("v%0d address_o", i), {224'h0, bus_if.address_o}, {224'h0, vecs[i].e_addr});
      if (vecs[i].chk_burst) begin
        chk($sformatf("v%0d burst_o", i), {192'h0, bus_if.burst_o}, {192'h0, vecs[i].e_burst});
      end
      if (i == 0) begin
        chk("reset line_o", bus_if.line_o, 256'h0);
      end
    end
    chk("read line kept after write", bus_if.line_o, {B3, B2, B1, B0});

    // Gapped read: resp_i pattern 1,0,0,1,1,0,1.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0047, 64'h0);
    step();
    chk("gap accept read_o", {255'h0, bus_if.read_o}, {255'h0, 1'b1});
    chk("gap address_o", {224'h0, bus_if.address_o}, {224'h0, 32'h8000_0040});
    begin
      int k;
      k = 0;
      for (int i = 0; i < 7; i++) begin
        drive(1'b0, 1'b1, 1'b0, gap_pat[i], 32'h8000_0047, gap_pat[i] ? cdat[k] : JUNK);
        step();
        if (gap_pat[i]) k++;
        if (i < 6) begin
          chk($sformatf("gap%0d read_o", i), {255'h0, bus_if.read_o}, {255'h0, 1'b1});
          chk($sformatf("gap%0d resp_o", i), {255'h0, bus_if.resp_o}, {255'h0, 1'b0});
        end else begin
          chk("gap end read_o", {255'h0, bus_if.read_o}, {255'h0, 1'b0});
          chk("gap end resp_o", {255'h0, bus_if.resp_o}, {255'h0, 1'b1});
        end
        if (i == 2) begin
          chk("gap partial line_o", bus_if.line_o, {B3, B2, B1, cdat[0]});
        end
      end
    end
    chk("gap line_o", bus_if.line_o, {cdat[3], cdat[2], cdat[1], cdat[0]});
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    step();
    chk("gap resp_o one cycle", {255'h0, bus_if.resp_o}, {255'h0, 1'b0});

    // Reset after the second read burst aborts without resp_o.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_2000, 64'h0);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_2000, B0);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_2000, B1);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_2000, B2);
    step();
    chk("abort read_o", {255'h0, bus_if.read_o}, {255'h0, 1'b0});
    chk("abort resp_o", {255'h0, bus_if.resp_o}, {255'h0, 1'b0});
    chk("abort line_o", bus_if.line_o, 256'h0);
    chk("abort address_o", {224'h0, bus_if.address_o}, 256'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, B3);
    step();
    chk("post abort resp_o", {255'h0, bus_if.resp_o}, {255'h0, 1'b0});
    chk("post abort read_o", {255'h0, bus_if.read_o}, {255'h0, 1'b0});

    // Fresh read after the abort.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_3010, 64'h0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_3010, fdat[i]);
      step();
      chk($sformatf("reread%0d resp_o", i), {255'h0, bus_if.resp_o}, {255'h0, (i == 3)});
    end
    chk("reread line_o", bus_if.line_o, {fdat[3], fdat[2], fdat[1], fdat[0]});
    chk("reread address_o", {224'h0, bus_if.address_o}, {224'h0, 32'h0000_3000});
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    step();
    chk("reread resp_o one cycle", {255'h0, bus_if.resp_o}, {255'h0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 Parameters SHALL be: s_line, 256, cache line width in bits; s_burst, 64, memory burst width in bits; num_bursts, 4, bursts per line (s_line/s_burst).
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 line_i  input  256  line from cache (pmem_wdata side), sampled when a write is accepted.
REQ-005 line_o  output  256  assembled line to cache (pmem_rdata side).
REQ-006 address_i  input  32  line address from cache.
REQ-007 read_i  input  1  cache line-read request, held high until resp_o.
REQ-008 write_i  input  1  cache line-write request, held high until resp_o.
REQ-009 resp_o  output  1  one-cycle completion pulse to cache.
REQ-010 burst_i  input  64  read burst data from memory.
REQ-011 burst_o  output  64  write burst data to memory.
REQ-012 address_o  output  32  burst-side address, line-aligned.
REQ-013 read_o  output  1  memory read request.
REQ-014 write_o  output  1  memory write request.
REQ-015 resp_i  input  1  memory burst acknowledge; one burst transferred per high cycle.

Function
REQ-016 FSM states SHALL be IDLE, READ, WRITE, DONE; read_o high only in READ, write_o high only in WRITE, resp_o high only in DONE.
REQ-017 IDLE: write_i high -> latch line_i and address_i, clear burst counter, go WRITE; else read_i high -> latch address_i, clear counter, go READ; write_i has priority if both high.
REQ-018 address_o SHALL equal latched address with bits [4:0] forced to zero; stable for the whole transaction.
REQ-019 READ: each cycle with resp_i high, burst_i SHALL be stored into line bits [64k+63:64k], k = counter, then counter increments.
REQ-020 WRITE: burst_o SHALL equal latched line bits [64k+63:64k]; counter increments on each resp_i high cycle.
REQ-021 Counter SHALL advance only on resp_i; gaps with resp_i low SHALL hold counter, data and requests unchanged.
REQ-022 On the cycle resp_i is high with counter = num_bursts-1, FSM SHALL go DONE; read_o/write_o low the next cycle.
REQ-023 DONE SHALL last exactly one cycle, assert resp_o, then return to IDLE unconditionally.
REQ-024 line_o SHALL be valid in DONE after a read and hold its value until the next read's first burst.
REQ-025 read_i/write_i SHALL be ignored outside IDLE; requester deasserts the cycle after resp_o, and the IDLE cycle following DONE is the earliest new acceptance.
REQ-026 resp_i outside READ/WRITE SHALL be ignored.
REQ-027 Latency: read with back-to-back resp_i completes resp_o 6 cycles after request sampled (1 accept, 4 bursts, 1 DONE); same for write.

Reset
REQ-028 rst high SHALL force IDLE, counter 0, read_o=0, write_o=0, resp_o=0, burst_o=0, address_o=0, line_o=0 on the next edge.
REQ-029 rst during READ/WRITE SHALL abort the transaction without resp_o; partially assembled data discarded.

Structure
REQ-030 Shared package cache_types SHALL hold s_line, s_burst, num_bursts constants and the adaptor state enum.
REQ-031 No sub-module; counter, line buffer and FSM SHALL be inline in cacheline_adaptor.

Verification
REQ-032 Read: address_i=0x0000_1234, bursts 0x11..,0x22..,0x33..,0x44.. back-to-back -> address_o=0x0000_1220, line_o={0x44..,0x33..,0x22..,0x11..}, single resp_o pulse 6 cycles after request.
REQ-033 Write: line_i=256'h{D,C,B,A} -> burst_o sequence A,B,C,D on successive resp_i, write_o drops after 4th, one resp_o.
REQ-034 Gapped read: resp_i pattern 1,0,0,1,1,0,1 -> four bursts captured in order, resp_o cycle after 7th.
REQ-035 read_i and write_i both high in IDLE -> write transaction performed, read_o never asserted.
REQ-036 rst asserted after 2nd read burst -> next cycle IDLE, read_o=0, no resp_o; subsequent read completes correctly.
REQ-037 Stray resp_i in IDLE and back-to-back read-then-write -> no state change from stray; both transactions complete with one resp_o each.
